// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the RV32I-subset core: decodes the instruction
// register and sequences each instruction over 3-5 cycles, driving ALU and datapath controls.
module multicycle_ctrl #(
  parameter int XLEN        = 32,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       eq,
  output logic [2:0] alu_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_run;

  logic [2:0] r_alu_ctrl,   w_alu_ctrl;
  logic [1:0] r_alu_src_a,  w_alu_src_a;
  logic [1:0] r_alu_src_b,  w_alu_src_b;
  logic [1:0] r_result_src, w_result_src;
  logic       r_adr_src,    w_adr_src;
  logic       r_ir_write,   w_ir_write;
  logic       r_pc_update,  w_pc_update;
  logic       r_branch,     w_branch;
  logic       r_reg_write,  w_reg_write;
  logic       r_mem_write,  w_mem_write;
  logic       r_instr_done, w_instr_done;
  logic       r_illegal,    w_illegal;

  logic [2:0] w_alu_dec;
  logic       w_f3_ok;
  logic       w_br_ok;

  // r_run holds the FSM in FETCH for the first edge after reset so FETCH controls appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_alu_dec = ALU_ADD;
    w_f3_ok   = 1'b1;
    case (funct3)
      3'b000:  w_alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_f3_ok   = 1'b0;
    endcase
    w_br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  end

  always_comb begin
    w_next_state = S_FETCH;
    if (r_run) begin
      case (r_state)
        S_FETCH:  w_next_state = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: w_next_state = S_MEMADR;
            OP_R:         w_next_state = w_f3_ok ? S_EXECR : S_TRAP;
            OP_I:         w_next_state = w_f3_ok ? S_EXECI : S_TRAP;
            OP_JAL:       w_next_state = S_JAL;
            OP_BR:        w_next_state = w_br_ok ? S_BRANCH : S_TRAP;
            default:      w_next_state = S_TRAP;
          endcase
        end
        S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  w_next_state = S_MEMWB;
        S_EXECR:    w_next_state = S_ALUWB;
        S_EXECI:    w_next_state = S_ALUWB;
        S_JAL:      w_next_state = S_ALUWB;
        S_TRAP:     w_next_state = TRAP_STICKY ? S_TRAP : S_FETCH;
        default:    w_next_state = S_FETCH;
      endcase
    end
  end

  // Controls are derived from the state being entered, then registered.
  always_comb begin
    w_alu_ctrl   = ALU_ADD;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (w_next_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_ctrl  = w_alu_dec;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_ctrl  = w_alu_dec;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_alu_ctrl   = ALU_SUB;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_ctrl   <= 3'b000;
      r_alu_src_a  <= 2'b00;
      r_alu_src_b  <= 2'b00;
      r_result_src <= 2'b00;
      r_adr_src    <= 1'b0;
      r_ir_write   <= 1'b0;
      r_pc_update  <= 1'b0;
      r_branch     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_alu_ctrl   <= w_alu_ctrl;
      r_alu_src_a  <= w_alu_src_a;
      r_alu_src_b  <= w_alu_src_b;
      r_result_src <= w_result_src;
      r_adr_src    <= w_adr_src;
      r_ir_write   <= w_ir_write;
      r_pc_update  <= w_pc_update;
      r_branch     <= w_branch;
      r_reg_write  <= w_reg_write;
      r_mem_write  <= w_mem_write;
      r_instr_done <= w_instr_done;
      r_illegal    <= w_illegal;
    end
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = 2'b00;
      OP_SW:       imm_src = 2'b01;
      OP_BR:       imm_src = 2'b10;
      OP_JAL:      imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  // funct3[0] distinguishes bne (taken on !eq) from beq (taken on eq).
  assign pc_write   = r_pc_update | (r_branch & (eq ^ funct3[0]));
  assign alu_ctrl   = r_alu_ctrl;
  assign alu_src_a  = r_alu_src_a;
  assign alu_src_b  = r_alu_src_b;
  assign result_src = r_result_src;
  assign adr_src    = r_adr_src;
  assign ir_write   = r_ir_write;
  assign reg_write  = r_reg_write;
  assign mem_write  = r_mem_write;
  assign instr_done = r_instr_done;
  assign illegal    = r_illegal;
  assign state_dbg  = r_state;

endmodule
